// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and limits for the OBI memory responder.
//   obi_resp_entry_t : one queued response (read data, error flag, age in cycles)
//   OBI_MAX_LATENCY  : largest supported accept-to-rvalid latency
//   OBI_MAX_OUTSTANDING : largest supported number of queued responses
package cv32e40p_obi_pkg;

    localparam int unsigned OBI_MAX_LATENCY     = 15;
    localparam int unsigned OBI_MAX_OUTSTANDING = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [3:0]  age;
    } obi_resp_entry_t;

    // Saturating age increment.
    function automatic logic [3:0] age_inc(input logic [3:0] age, input logic [3:0] sat);
        return (age >= sat) ? sat : age + 4'd1;
    endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response queue with per-entry age tracking.
//   clk, rst    : clock, synchronous active-high reset (empties the queue)
//   push        : enqueue push_entry (its age is forced to 0)
//   pop         : dequeue the head (caller only pops when not empty)
//   head        : oldest entry
//   count       : number of valid entries
//   empty, full : queue status
// Entry 0 is always the head; a pop shifts the remaining entries down.
module cv32e40p_obi_resp_fifo
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned AGE_MAX = 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  obi_resp_entry_t  push_entry,
    input  logic             pop,
    output obi_resp_entry_t  head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [3:0] SAT = 4'(AGE_MAX);

    obi_resp_entry_t  q      [DEPTH];
    obi_resp_entry_t  q_next [DEPTH];
    logic [CNT_W-1:0] count_next;
    int               wr_slot;
    logic             unused_age;

    assign unused_age = ^push_entry.age;

    always_comb begin
        wr_slot = int'(count) - (pop ? 1 : 0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pop && (i < DEPTH - 1)) begin
                q_next[i] = q[(i + 1) % DEPTH];
            end else begin
                q_next[i] = q[i];
            end
            q_next[i].age = age_inc(q_next[i].age, SAT);
            if (push && (int'(i) == wr_slot)) begin
                q_next[i]     = push_entry;
                q_next[i].age = '0;
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
        q <= q_next;
    end

    assign head  = q[0];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// Memory-side OBI responder: word-addressed memory with byte enables,
// programmable grant stall, fixed response latency, in-order response queue.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i/gnt_o  : request / grant (gnt_o combinational)
//   addr_i       : byte address (word index = addr_i[$clog2(DEPTH)+1:2])
//   we_i, be_i, wdata_i : write enable, byte enables, write data
//   rvalid_o, rdata_o   : registered response
//   gnt_stall_i  : cycles req_i must be held before a grant
//   err_o        : only when CV32E40P_OBI_RESP_ERR_EN is defined; flags
//                  accesses at or beyond DEPTH*4 (no write, data 0)
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RVALID_LATENCY  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic [3:0]  gnt_stall_i
`ifdef CV32E40P_OBI_RESP_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam bit          BYPASS  = (RVALID_LATENCY == 1);
    // A stored entry has already lived one cycle (its accept cycle) when its
    // age reads 0, so it is due when age == RVALID_LATENCY-2. Latency 1
    // answers straight from the accept cycle and never touches the queue.
    localparam logic [3:0]  POP_AGE = (RVALID_LATENCY >= 2) ? 4'(RVALID_LATENCY - 2) : 4'd0;

    logic [31:0]      mem [DEPTH];
    logic [3:0]       stall_cnt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             oob;
    logic             push;
    logic             pop;
    logic             resp_valid;
    obi_resp_entry_t  new_entry;
    obi_resp_entry_t  head;
    obi_resp_entry_t  resp_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             unused_bits;

    assign idx = addr_i[IDX_W+1:2];

`ifdef CV32E40P_OBI_RESP_ERR_EN
    assign oob = ((addr_i >> (IDX_W + 2)) != '0);
`else
    assign oob = 1'b0;
`endif

    assign unused_bits = ^{addr_i[1:0], (addr_i >> (IDX_W + 2)), fifo_count,
                           resp_entry.age, resp_entry.err};

    // fifo_full uses the registered count, so a same-cycle pop frees nothing.
    assign gnt_o  = !rst_i && req_i && (stall_cnt >= gnt_stall_i) && !fifo_full;
    assign accept = req_i && gnt_o;

    always_comb begin
        new_entry      = '0;
        new_entry.err  = oob;
        new_entry.data = (we_i || oob) ? 32'h0 : mem[idx];
        push           = accept && !BYPASS;
        pop            = !BYPASS && !fifo_empty && (head.age == POP_AGE);
        resp_valid     = BYPASS ? accept : pop;
        resp_entry     = BYPASS ? new_entry : head;
    end

    cv32e40p_obi_resp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .AGE_MAX (RVALID_LATENCY)
    ) u_resp_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!req_i || accept) begin
            stall_cnt <= '0;
        end else if (stall_cnt != 4'hF) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

    // Memory is deliberately not reset; gnt_o is low in reset so no write lands.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !oob) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= resp_valid;
            if (resp_valid) begin
                rdata_o <= resp_entry.data;
            end
        end
    end

`ifdef CV32E40P_OBI_RESP_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= resp_valid && resp_entry.err;
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder: two instances (latency 1 and 3,
// MAX_OUTSTANDING 2) driven by shared inputs. A per-instance reference model
// (response list keyed by due cycle, outstanding = responses not yet due)
// checks every cycle; directed vectors and sequences check the corner cases.
module tb_cv32e40p_obi_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int          MAXO  = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be, gstall;

    logic        gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b;
`ifdef CV32E40P_OBI_RESP_ERR_EN
    logic        err_a, err_b;
`endif

    cv32e40p_obi_mem_responder #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RVALID_LATENCY(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .gnt_stall_i(gstall)
`ifdef CV32E40P_OBI_RESP_ERR_EN
        , .err_o(err_a)
`endif
    );

    cv32e40p_obi_mem_responder #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RVALID_LATENCY(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .gnt_stall_i(gstall)
`ifdef CV32E40P_OBI_RESP_ERR_EN
        , .err_o(err_b)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Outputs captured at the falling edge of the current cycle.
    logic        cg  [2];
    logic        crv [2];
    logic [31:0] crd [2];
    logic        cer [2];

    typedef struct {
        int          dut;
        int          due;
        logic [31:0] data;
        bit          known;
        bit          err;
    } resp_t;

    resp_t       pend [$];
    logic [31:0] mm [2][DEPTH];
    bit          mk [2][DEPTH];
    int          stall_m [2];
    logic [31:0] last_d [2];
    bit          last_k [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic model(input int dd);
        int          lat, outst, idx;
        bit          exp_rv, eg, oob, kv;
        logic [31:0] dv;
        resp_t       r;
        lat    = (dd == 0) ? 1 : 3;
        exp_rv = 1'b0;
        r      = '{default: 0};
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].dut == dd) begin
                if (pend[i].due == cyc) begin
                    r      = pend[i];
                    exp_rv = 1'b1;
                    pend.delete(i);
                end
                break;
            end
        end
        chk1($sformatf("model_rvalid[%0d]", dd), crv[dd], exp_rv);
        if (exp_rv) begin
            last_d[dd] = r.data;
            last_k[dd] = r.known;
`ifdef CV32E40P_OBI_RESP_ERR_EN
            chk1($sformatf("model_err[%0d]", dd), cer[dd], r.err);
`endif
        end
        if (last_k[dd]) chk($sformatf("model_rdata[%0d]", dd), crd[dd], last_d[dd]);

        outst = 0;
        foreach (pend[i]) if (pend[i].dut == dd) outst++;
        eg = !rst && req && (stall_m[dd] >= int'(gstall)) && (outst < MAXO);
        chk1($sformatf("model_gnt[%0d]", dd), cg[dd], eg);

        if (rst) begin
            for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].dut == dd) pend.delete(i);
            stall_m[dd] = 0;
            last_d[dd]  = '0;
            last_k[dd]  = 1'b1;
        end else begin
            if (eg) begin
                idx = int'(addr[11:2]);
`ifdef CV32E40P_OBI_RESP_ERR_EN
                oob = (addr >= 32'(DEPTH * 4));
`else
                oob = 1'b0;
`endif
                if (we) begin
                    dv = '0;
                    kv = 1'b1;
                    if (!oob) begin
                        for (int k = 0; k < 4; k++)
                            if (be[k]) mm[dd][idx][8*k +: 8] = wdata[8*k +: 8];
                        mk[dd][idx] = mk[dd][idx] || (be == 4'hF);
                    end
                end else if (oob) begin
                    dv = '0;
                    kv = 1'b1;
                end else begin
                    dv = mm[dd][idx];
                    kv = mk[dd][idx];
                end
                r.dut   = dd;
                r.due   = cyc + lat;
                r.data  = dv;
                r.known = kv;
                r.err   = oob;
                pend.push_back(r);
            end
            if (!req || eg) stall_m[dd] = 0;
            else if (stall_m[dd] < 15) stall_m[dd]++;
        end
    endtask

    // One clock cycle: apply inputs, sample at the falling edge, run the model.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [3:0] st, input logic rs);
        req = r; we = w; addr = a; be = b; wdata = d; gstall = st; rst = rs;
        @(negedge clk);
        cg[0] = gnt_a; crv[0] = rvalid_a; crd[0] = rdata_a;
        cg[1] = gnt_b; crv[1] = rvalid_b; crd[1] = rdata_b;
`ifdef CV32E40P_OBI_RESP_ERR_EN
        cer[0] = err_a; cer[1] = err_b;
`else
        cer[0] = 1'b0; cer[1] = 1'b0;
`endif
        model(0);
        model(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    typedef struct {
        logic        req, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_gnt, exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  g_pat, v_pat;
        logic [9:0]  r_pat, s_pat;
        int          nxt, ridx;

        tbl[0] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b1, 32'h10, 4'h5, 32'hAABBCCDD, 1'b1, 1'b1, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h11BB33DD};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'h11BB33DD};

        for (int d = 0; d < 2; d++) begin
            stall_m[d] = 0; last_d[d] = '0; last_k[d] = 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) mk[d][i] = 1'b0;
        end

        req = 0; we = 0; addr = '0; be = '0; wdata = '0; gstall = '0; rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, with req_i high to confirm no grant during reset.
        step(1'b1, 1'b0, 32'h0, 4'hF, '0, '0, 1'b1);
        chk1("reset_gnt", cg[0], 1'b0);
        chk1("reset_rvalid", crv[0], 1'b0);
        chk("reset_rdata", crd[0], 32'h0);
        chk1("reset_rvalid_lat3", crv[1], 1'b0);

        // Fill the words used below (spacing keeps the latency-3 queue empty).
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i), '0, 1'b0);
            idle(2);
        end
        idle(2);

        // Latency 1 write/read and byte-enable merge.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, '0, 1'b0);
            chk1($sformatf("vec%0d_gnt", i), cg[0], tbl[i].exp_gnt);
            chk1($sformatf("vec%0d_rvalid", i), crv[0], tbl[i].exp_rv);
            chk($sformatf("vec%0d_rdata", i), crd[0], tbl[i].exp_rd);
        end
        idle(3);

        // Latency 3, two outstanding, req_i held for three reads.
        g_pat = 8'b0000_1011;
        v_pat = 8'b0101_1000;
        nxt   = 0;
        ridx  = 0;
        for (int k = 0; k < 8; k++) begin
            step(nxt < 3, 1'b0, 32'(nxt * 4), 4'hF, '0, '0, 1'b0);
            chk1($sformatf("full_gnt_k%0d", k), cg[1], g_pat[k]);
            chk1($sformatf("full_rvalid_k%0d", k), crv[1], v_pat[k]);
            if (crv[1]) begin
                chk($sformatf("full_rdata_%0d", ridx), crd[1], 32'hC0DE0000 + 32'(ridx));
                ridx++;
            end
            if (nxt < 3 && cg[1]) nxt++;
        end
        idle(2);

        // Grant stall of 2, including a dropped request restarting the count.
        r_pat = 10'h1D7;
        s_pat = 10'h104;
        for (int k = 0; k < 10; k++) begin
            step(r_pat[k], 1'b0, 32'h10, 4'hF, '0, 4'd2, 1'b0);
            chk1($sformatf("stall_gnt_k%0d", k), cg[0], s_pat[k]);
        end
        idle(3);

        // Reset with two latency-3 reads outstanding.
        step(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, '0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 32'h20, 4'hF, '0, '0, 1'b0);
        step(1'b1, 1'b0, 32'h24, 4'hF, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
            chk1($sformatf("rst_rvalid_lat3_k%0d", k), crv[1], 1'b0);
            chk1($sformatf("rst_rvalid_lat1_k%0d", k), crv[0], 1'b0);
        end
        chk("rst_rdata_lat3", crd[1], 32'h0);
        step(1'b1, 1'b0, 32'h20, 4'hF, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        chk1("persist_rvalid_lat1", crv[0], 1'b1);
        chk("persist_rdata_lat1", crd[0], 32'h12345678);
        idle(1);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        chk1("persist_rvalid_lat3", crv[1], 1'b1);
        chk("persist_rdata_lat3", crd[1], 32'h12345678);
        idle(3);

`ifdef CV32E40P_OBI_RESP_ERR_EN
        step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h55AA55AA, '0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 4'hF, '0, '0, 1'b0);
        chk1("err_wr_rvalid", crv[0], 1'b1);
        chk1("err_wr_err", cer[0], 1'b1);
        chk("err_wr_rdata", crd[0], 32'h0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        chk1("err_rd_rvalid", crv[0], 1'b1);
        chk1("err_rd_err", cer[0], 1'b0);
        chk("err_rd_rdata", crd[0], 32'hC0DE0000);
        idle(3);
`endif

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            logic [31:0] a;
            logic [3:0]  st;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
            st = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, 1'($urandom), a, 4'($urandom), $urandom, st,
                 $urandom_range(0, 79) == 0);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
